// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the instruction-memory loader.
// Holds opcodes, the field-stream kind encoding, the loader FSM states and the encoder input bundle.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        KIND_LW  = 2'b00,
        KIND_SW  = 2'b01,
        KIND_R   = 2'b10,
        KIND_BEQ = 2'b11
    } instr_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10
    } ld_state_e;

    typedef struct packed {
        instr_kind_e kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [12:0] imm;
    } instr_fields_t;

endpackage

// File: rtl/riscv_instr_encoder.sv
// Combinational RV32I encoder for LW/SW/R-type/BEQ field bundles.
// Flags field combinations that have no legal RV32I encoding.
module riscv_instr_encoder
    import riscv_pkg::*;
(
    input  instr_fields_t fields,
    output logic [31:0]   word,
    output logic          illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fields.kind)
            KIND_LW: word = {fields.imm[11:0], fields.rs1, 3'b010, fields.rd, OPC_LOAD};
            KIND_SW: word = {fields.imm[11:5], fields.rs2, fields.rs1, 3'b010,
                             fields.imm[4:0], OPC_STORE};
            KIND_R: begin
                word    = {1'b0, fields.funct7b5, 5'b00000, fields.rs2, fields.rs1,
                           fields.funct3, fields.rd, OPC_OP};
                // Only ADD/SUB, SLT, OR, AND are accepted; funct7b5 is meaningful for SUB only
                illegal = !(fields.funct3 inside {3'b000, 3'b010, 3'b110, 3'b111}) ||
                          (fields.funct7b5 && fields.funct3 != 3'b000);
            end
            KIND_BEQ: begin
                word    = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1, 3'b000,
                           fields.imm[4:1], fields.imm[11], OPC_BRANCH};
                illegal = fields.imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_imem_loader.sv
// Streams instruction fields in, encodes them and writes words to sequential imem addresses.
// A session writes num_instr legal words; illegal fields are dropped and latch err.
module riscv_imem_loader
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  num_instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic [12:0] in_imm,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    ld_state_e     state, state_nxt;
    logic [7:0]    remain;
    logic [31:0]   wr_ptr;
    instr_fields_t fields;
    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic          fire, fire_ok, start_ok, last_word;

    assign fields = '{kind:     instr_kind_e'(in_kind),
                      rd:       in_rd,
                      rs1:      in_rs1,
                      rs2:      in_rs2,
                      funct3:   in_funct3,
                      funct7b5: in_funct7b5,
                      imm:      in_imm};

    riscv_instr_encoder u_enc (
        .fields  (fields),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign fire      = in_valid && in_ready;
    assign fire_ok   = fire && !enc_illegal;
    assign start_ok  = (state == ST_IDLE) && start;
    assign last_word = fire_ok && (remain == 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        busy      = imem_we;
        case (state)
            ST_IDLE: if (start) state_nxt = (num_instr == 8'd0) ? ST_DONE : ST_LOAD;
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_word) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write port lags acceptance by one cycle, so the last write lands in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain     <= '0;
            wr_ptr     <= BASE_ADDR;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            err        <= 1'b0;
        end else begin
            imem_we <= fire_ok;
            if (start_ok) begin
                remain <= num_instr;
                wr_ptr <= BASE_ADDR;
                err    <= 1'b0;
            end
            if (fire_ok) begin
                imem_addr  <= wr_ptr;
                imem_wdata <= enc_word;
                wr_ptr     <= wr_ptr + 32'd4;
                remain     <= remain - 8'd1;
            end
            if (fire && enc_illegal) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Directed bench for riscv_imem_loader: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_riscv_imem_loader;
    import riscv_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_instr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic [12:0] in_imm = '0;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        busy, done, err;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    riscv_imem_loader #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_instr(num_instr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", imem_addr, mon_e[63:32]);
                check("wr_data", imem_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        start     = 1'b1;
        num_instr = n;
        tick();
        start     = 1'b0;
    endtask

    // Leaves in_valid high so callers can chain transfers back-to-back
    task automatic drive(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                         input logic [12:0] imm);
        in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7b5 = f7; in_imm = imm;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !in_ready; n++) tick();
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1");
        end
        tick();
    endtask

    task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [12:0] imm);
        drive(k, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_we"}, imem_we, 0);
        check({tag, "_addr"}, imem_addr, BASE);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst");
        #20 rst_n = 1'b1;
        tick(); tick();
        check("idle_ready", in_ready, 0);

        // lw x5,4(x0)
        do_start(8'd1);
        check("load_ready", in_ready, 1);
        check("load_busy", busy, 1);
        exp_q.push_back({BASE, 32'h00402283});
        send(KIND_LW, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 13'd4);
        check("lw_done", done, 1);
        check("lw_we_with_done", imem_we, 1);
        check("lw_ready_drop", in_ready, 0);
        tick();
        check("lw_done_1cyc", done, 0);
        check("lw_busy_off", busy, 0);

        // sw x6,8(x0) then sub x4,x1,x2 back-to-back
        do_start(8'd2);
        exp_q.push_back({BASE, 32'h00602423});
        send(KIND_SW, 5'd0, 5'd0, 5'd6, 3'd0, 1'b0, 13'd8);
        check("sw_we", imem_we, 1);
        exp_q.push_back({BASE + 32'd4, 32'h40208233});
        send(KIND_R, 5'd4, 5'd1, 5'd2, 3'b000, 1'b1, 13'd0);
        check("sub_we_b2b", imem_we, 1);
        check("sub_done", done, 1);
        tick();

        // beq x4,x0,-4; odd BEQ and bad R-types dropped; or x3,x1,x2; beq x1,x2,8
        do_start(8'd3);
        exp_q.push_back({BASE, 32'hFE020EE3});
        send(KIND_BEQ, 5'd0, 5'd4, 5'd0, 3'd0, 1'b0, 13'h1FFC);
        send(KIND_BEQ, 5'd0, 5'd4, 5'd0, 3'd0, 1'b0, 13'h0003);
        check("beq_odd_err", err, 1);
        check("beq_odd_no_we", imem_we, 0);
        check("beq_odd_still_load", in_ready, 1);
        send(KIND_R, 5'd3, 5'd1, 5'd2, 3'b001, 1'b0, 13'd0);
        send(KIND_R, 5'd3, 5'd1, 5'd2, 3'b010, 1'b1, 13'd0);
        check("r_illegal_no_we", imem_we, 0);
        exp_q.push_back({BASE + 32'd4, 32'h0020E1B3});
        send(KIND_R, 5'd3, 5'd1, 5'd2, 3'b110, 1'b0, 13'd0);
        exp_q.push_back({BASE + 32'd8, 32'h00208463});
        send(KIND_BEQ, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h0008);
        check("beq_done", done, 1);
        check("err_sticky_done", err, 1);
        tick();
        check("err_sticky_idle", err, 1);

        // empty session
        do_start(8'd0);
        check("empty_err_clear", err, 0);
        check("empty_done", done, 1);
        check("empty_ready", in_ready, 0);
        check("empty_we", imem_we, 0);
        tick();
        check("empty_done_1cyc", done, 0);
        check("empty_ready_idle", in_ready, 0);

        // reset after 2 of 4 writes with in_valid held
        do_start(8'd4);
        exp_q.push_back({BASE, 32'h01012083});
        drive(KIND_LW, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 13'h010);
        exp_q.push_back({BASE + 32'd4, 32'h01412103});
        drive(KIND_LW, 5'd2, 5'd2, 5'd0, 3'd0, 1'b0, 13'h014);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_ready", in_ready, 0);
        check("post_rst_we", imem_we, 0);
        in_valid = 1'b0;

        do_start(8'd1);
        exp_q.push_back({BASE, 32'h00402283});
        send(KIND_LW, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 13'd4);
        check("restart_done", done, 1);
        tick(); tick();

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
